ppi_control_logic: RTL and testbench
====================================

Name: ppi_control_logic

Overview:
- Control/configuration block for the PPI.
- Decodes CPU writes to the control register (mode-set and port C bit set/reset), and drives per-port direction flags and a global port enable for the port nibble/byte tristate blocks.
- Holds the port C output latch.
- Runs the group A mode 1 strobed-input handshake (STB/IBF/INTR) on PC4/PC5/PC3.
- Sits between the CPU bus interface and the port A, port B and port C tristate blocks.

Parameters:
- RESET_CW, 8'h9B, control word loaded at reset (mode 0, all ports input)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cs  input  1  chip select, qualifies wr/rd
- wr  input  1  single-cycle write strobe
- rd  input  1  single-cycle read strobe
- addr  input  2  register select: 0=A, 1=B, 2=C, 3=control
- din  input  8  CPU write data
- ctrl_word  output  8  current mode control word
- a_is_input  output  1  port A direction (1=input, 0=output)
- b_is_input  output  1  port B direction
- pc_dir  output  8  per-bit port C direction (1=input)
- pc_out  output  8  port C output latch/handshake value
- ports_en  output  1  global port enable (0 = all ports tristated)
- stb_n  input  1  port A strobe from peripheral (PC4), active low
- latch_a  output  1  one-cycle load pulse for the port A input latch
- ibf_a  output  1  input buffer full (drives pc_out[5] in mode 1)
- intr_a  output  1  interrupt request (drives pc_out[3] in mode 1)

Behaviour:
- Reset: ctrl_word=RESET_CW; pc latch=0; ibf_a=0; intr_a=0; latch_a=0; FSM=IDLE; ports_en=0.
- ports_en rises to 1 on the first cycle after reset deasserts.
- Write accepted when cs&wr&addr==3. All updates are visible the cycle after acceptance (1-cycle latency).
- Mode-set (din[7]=1):
  - din[6:5]=00 selects mode 0; 01 selects mode 1.
  - din[6:5]=1x is reserved: the whole word is ignored and no state changes.
  - Otherwise, in one cycle: ctrl_word<=din; pc latch<=0; ibf_a<=0; intr_a<=0; FSM<=IDLE; ports_en<=0.
  - ports_en returns to 1 on the following cycle, giving a one-cycle reconfiguration blackout.
  - din[2] (group B mode) is stored; group B always operates as mode 0.
- BSR (din[7]=0): pc latch bit din[3:1] <= din[0]. ctrl_word is unchanged. No blackout.
- Direction outputs:
  - a_is_input = ctrl_word[4].
  - b_is_input = ctrl_word[1].
  - pc_dir[7:4] = ctrl_word[3] (upper nibble); pc_dir[3:0] = ctrl_word[0] (lower nibble).
- Mode 1 group A overrides:
  - pc_dir[3]=0 (INTR out), pc_dir[4]=1 (STB in), pc_dir[5]=0 (IBF out).
  - pc_out[3]=intr_a and pc_out[5]=ibf_a; all other pc_out bits come from the latch.
  - INTE_A = pc latch bit 4, set through BSR.
- Mode 0: pc_out = latch; ibf_a, intr_a and latch_a are held 0 and the FSM stays in IDLE.
- Handshake FSM (mode 1 only). stb_n edges are detected against a registered copy of stb_n.
  - IDLE: on stb_n falling edge, latch_a=1 for one cycle, ibf_a<=1, go to STROBED.
  - STROBED: on stb_n rising edge, intr_a<=INTE_A, go to FULL.
    - A read (cs&rd&addr==0) in this state clears ibf_a and returns to IDLE; intr_a is never set.
  - FULL: on a read (cs&rd&addr==0), intr_a<=0, ibf_a<=0, go to IDLE.
    - A new stb_n falling edge while in FULL is ignored (no latch_a); the data stays protected.
  - Read and stb_n falling edge in the same cycle in IDLE: the strobe wins (latch_a, ibf_a=1).
  - Clearing INTE_A via BSR while intr_a=1 clears intr_a on the next cycle.
- reset asserted mid-handshake returns everything to reset values on the next edge.
- Reads never modify ctrl_word or the pc latch.

Optional Feature:
- Macro PPI_STB_SYNC_EN.
- Defined: stb_n passes through a 2-flop synchronizer (reset value 1) before edge detection, so strobe-to-latch_a latency is 3 cycles.
- Undefined: stb_n is used directly (registered once for edge detection only), so latency is 1 cycle.
- All tests state latency for the undefined case; add 2 cycles when the macro is defined.

Test Plan:
- Reset then idle: ctrl_word=8'h9B, a_is_input=1, b_is_input=1, pc_dir=8'hFF, pc_out=0, ports_en=0 then 1 one cycle after reset drops.
- Write 8'h80 to addr 3 -> next cycle ctrl_word=8'h80, all directions 0, ports_en=0 for exactly one cycle then 1, pc_out=0.
- After 8'h80, BSR writes 8'h0F (set bit 7) then 8'h01 (set bit 0) -> pc_out=8'h81; then write 8'h0E -> pc_out=8'h01; ctrl_word stays 8'h80.
- Write 8'hC0 (reserved mode) -> ctrl_word, pc_out and ports_en unchanged.
- Mode 1: write 8'hB0, BSR 8'h09 (INTE_A=1), drive stb_n low -> latch_a pulse, ibf_a=1, pc_out[5]=1; stb_n high -> intr_a=1; read addr 0 -> intr_a=0, ibf_a=0 next cycle.
- In FULL, pulse stb_n low again -> no latch_a, ibf_a stays 1; assert reset mid-handshake -> ibf_a=0, intr_a=0, ctrl_word=8'h9B.

Source files
------------

// File: rtl/ppi_control_logic.sv
// PPI control register decode, port C latch and group A mode 1 strobed-input handshake.
// Optional macro PPI_STB_SYNC_EN adds a 2-flop synchronizer on stb_n (+2 cycles latency).
module ppi_control_logic #(
  parameter logic [7:0] RESET_CW = 8'h9B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] ctrl_word,
  output logic       a_is_input,
  output logic       b_is_input,
  output logic [7:0] pc_dir,
  output logic [7:0] pc_out,
  output logic       ports_en,
  input  logic       stb_n,
  output logic       latch_a,
  output logic       ibf_a,
  output logic       intr_a,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STROBED = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [7:0] pc_latch, latch_nxt;
  logic [1:0] state, state_nxt;
  logic       ibf_nxt, intr_nxt, latch_a_nxt;
  logic       stb_s, stb_q, stb_fall, stb_rise;
  logic       ctl_wr, rd_a, mode_set, bsr, mode1;

`ifdef PPI_STB_SYNC_EN
  logic stb_m1, stb_m2;
  always_ff @(posedge clk) begin
    if (reset) begin
      stb_m1 <= 1'b1;
      stb_m2 <= 1'b1;
    end else begin
      stb_m1 <= stb_n;
      stb_m2 <= stb_m1;
    end
  end
  assign stb_s = stb_m2;
`else
  assign stb_s = stb_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) stb_q <= 1'b1;
    else       stb_q <= stb_s;
  end

  assign stb_fall = stb_q & ~stb_s;
  assign stb_rise = ~stb_q & stb_s;
  assign ctl_wr   = cs & wr & (addr == 2'd3);
  assign rd_a     = cs & rd & (addr == 2'd0);
  // Reserved mode words (din[6]=1) are dropped entirely.
  assign mode_set = ctl_wr & din[7] & ~din[6];
  assign bsr      = ctl_wr & ~din[7];
  assign mode1    = (ctrl_word[6:5] == 2'b01);

  always_comb begin
    latch_nxt = pc_latch;
    if (bsr) latch_nxt[din[3:1]] = din[0];
  end

  // Handshake next state. A read in STROBED wins over a simultaneous rising strobe.
  always_comb begin
    state_nxt   = state;
    ibf_nxt     = ibf_a;
    intr_nxt    = intr_a;
    latch_a_nxt = 1'b0;
    if (mode1) begin
      case (state)
        ST_IDLE: begin
          if (stb_fall) begin
            latch_a_nxt = 1'b1;
            ibf_nxt     = 1'b1;
            state_nxt   = ST_STROBED;
          end
        end
        ST_STROBED: begin
          if (rd_a) begin
            ibf_nxt   = 1'b0;
            state_nxt = ST_IDLE;
          end else if (stb_rise) begin
            intr_nxt  = pc_latch[4];
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (rd_a) begin
            ibf_nxt   = 1'b0;
            intr_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      // INTE_A gates the request; clearing it drops a pending interrupt.
      intr_nxt = intr_nxt & latch_nxt[4];
    end else begin
      state_nxt = ST_IDLE;
      ibf_nxt   = 1'b0;
      intr_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_word <= RESET_CW;
      pc_latch  <= 8'h00;
      state     <= ST_IDLE;
      ibf_a     <= 1'b0;
      intr_a    <= 1'b0;
      latch_a   <= 1'b0;
      ports_en  <= 1'b0;
    end else if (mode_set) begin
      ctrl_word <= din;
      pc_latch  <= 8'h00;
      state     <= ST_IDLE;
      ibf_a     <= 1'b0;
      intr_a    <= 1'b0;
      latch_a   <= 1'b0;
      ports_en  <= 1'b0;
    end else begin
      pc_latch  <= latch_nxt;
      state     <= state_nxt;
      ibf_a     <= ibf_nxt;
      intr_a    <= intr_nxt;
      latch_a   <= latch_a_nxt;
      ports_en  <= 1'b1;
    end
  end

  always_comb begin
    a_is_input = ctrl_word[4];
    b_is_input = ctrl_word[1];
    pc_dir     = {{4{ctrl_word[3]}}, {4{ctrl_word[0]}}};
    pc_out     = pc_latch;
    if (mode1) begin
      pc_dir[3] = 1'b0;
      pc_dir[4] = 1'b1;
      pc_dir[5] = 1'b0;
      pc_out[3] = intr_a;
      pc_out[5] = ibf_a;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_ppi_control_logic.sv
// Scoreboard bench for ppi_control_logic: directed test-plan sequence, then random traffic
// checked every cycle against a behavioural model of the PPI control block.
module tb_ppi_control_logic;

`ifdef PPI_STB_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic       stb_n = 1'b1;
  logic [7:0] ctrl_word, pc_dir, pc_out;
  logic       a_is_input, b_is_input, ports_en, latch_a, ibf_a, intr_a;
  logic [1:0] fsm_state;

  ppi_control_logic #(.RESET_CW(8'h9B)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
    .ctrl_word(ctrl_word), .a_is_input(a_is_input), .b_is_input(b_is_input),
    .pc_dir(pc_dir), .pc_out(pc_out), .ports_en(ports_en), .stb_n(stb_n),
    .latch_a(latch_a), .ibf_a(ibf_a), .intr_a(intr_a), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_cw = 8'h9B;
  logic [7:0] m_latch = 8'h00;
  logic       m_ibf = 0, m_intr = 0, m_lat = 0, m_pen = 0;
  int         m_phase = 0;            // 0 waiting for strobe, 1 strobe held low, 2 data held
  logic       stb_hist[$];            // stb_n as sampled at past edges, newest at back

  logic [29:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [29:0] model_outputs();
    logic [7:0] dir, po;
    logic m1;
    m1 = (m_cw[6:5] == 2'b01);
    for (int i = 0; i < 8; i++) begin
      dir[i] = (i >= 4) ? m_cw[3] : m_cw[0];
      po[i]  = m_latch[i];
    end
    if (m1) begin
      dir[3] = 1'b0; dir[4] = 1'b1; dir[5] = 1'b0;
      po[3] = m_intr; po[5] = m_ibf;
    end
    return {m_cw, m_cw[4], m_cw[1], dir, po, m_pen, m_lat, m_ibf, m_intr};
  endfunction

  task automatic model_edge(input logic r, c, w, rdi, input logic [1:0] a,
                            input logic [7:0] d, input logic s);
    logic s_eff, s_prev, fall, rise, wr_ctl, rd0;
    logic [7:0] nl;
    int n;
    if (r) begin
      m_cw = 8'h9B; m_latch = 0; m_ibf = 0; m_intr = 0; m_lat = 0; m_pen = 0; m_phase = 0;
      stb_hist = '{1'b1, 1'b1, 1'b1};
      return;
    end
    n = stb_hist.size();
    s_eff  = (SYNC_D == 0) ? s : stb_hist[n - SYNC_D];
    s_prev = stb_hist[n - SYNC_D - 1];
    fall = s_prev && !s_eff;
    rise = !s_prev && s_eff;
    stb_hist.push_back(s);
    if (stb_hist.size() > 3) void'(stb_hist.pop_front());
    wr_ctl = c && w && (a == 2'd3);
    rd0    = c && rdi && (a == 2'd0);
    if (wr_ctl && d[7] && !d[6]) begin
      m_cw = d; m_latch = 0; m_ibf = 0; m_intr = 0; m_lat = 0; m_pen = 0; m_phase = 0;
      return;
    end
    m_pen = 1; m_lat = 0;
    nl = m_latch;
    if (wr_ctl && !d[7]) nl[d[3:1]] = d[0];
    if (m_cw[6:5] == 2'b01) begin
      if (m_phase == 0 && fall) begin
        m_lat = 1; m_ibf = 1; m_phase = 1;
      end else if (m_phase == 1 && rd0) begin
        m_ibf = 0; m_phase = 0;
      end else if (m_phase == 1 && rise) begin
        m_intr = m_latch[4]; m_phase = 2;
      end else if (m_phase == 2 && rd0) begin
        m_ibf = 0; m_intr = 0; m_phase = 0;
      end
      if (!nl[4]) m_intr = 0;
    end else begin
      m_ibf = 0; m_intr = 0; m_phase = 0;
    end
    m_latch = nl;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, c, w, rdi, input logic [1:0] a,
                      input logic [7:0] d, input logic s);
    reset = r; cs = c; wr = w; rd = rdi; addr = a; din = d; stb_n = s;
    model_edge(r, c, w, rdi, a, d, s);
    @(posedge clk);
    #1;
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input logic s, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'd0, 8'h00, s);
  endtask

  task automatic cw_write(input logic [7:0] d, input logic s);
    step(0, 1, 1, 0, 2'd3, d, s);
  endtask

  task automatic read_a(input logic s);
    step(0, 1, 0, 1, 2'd0, 8'h00, s);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [29:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {ctrl_word, a_is_input, b_is_input, pc_dir, pc_out, ports_en, latch_a, ibf_a, intr_a};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got cw=%h dir=%h pc=%h en=%b lat=%b ibf=%b intr=%b, need cw=%h dir=%h pc=%h en=%b lat=%b ibf=%b intr=%b",
                 $time, act[29:22], act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                 e[29:22], e[19:12], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic cur_stb;
    logic [7:0] d;
    int pick;
    stb_hist = '{1'b1, 1'b1, 1'b1};
    step(1, 0, 0, 0, 2'd0, 8'h00, 1);
    step(1, 0, 0, 0, 2'd0, 8'h00, 1);
    idle(1, 3);

    // mode 0 all outputs, BSR and reserved word
    cw_write(8'h80, 1);
    idle(1, 2);
    cw_write(8'h0F, 1);
    cw_write(8'h01, 1);
    idle(1, 1);
    cw_write(8'h0E, 1);
    cw_write(8'hC0, 1);
    cw_write(8'hE5, 1);
    idle(1, 2);

    // mode 1 handshake with INTE_A set
    cw_write(8'hB0, 1);
    cw_write(8'h09, 1);
    idle(1, 1);
    idle(0, 4);
    idle(1, 4);
    read_a(1);
    idle(1, 2);

    // read while strobed, then strobe and read together in idle
    idle(0, 4);
    read_a(0);
    idle(1, 3);
    step(0, 0, 0, 0, 2'd0, 8'h00, 1);
    for (int i = 0; i < SYNC_D; i++) step(0, 0, 0, 0, 2'd0, 8'h00, 0);
    step(0, 1, 0, 1, 2'd0, 8'h00, 0);
    idle(1, 4);
    read_a(1);
    idle(1, 2);

    // FULL: extra strobe ignored, INTE_A cleared drops intr, then reset mid-handshake
    idle(0, 4);
    idle(1, 4);
    idle(0, 4);
    idle(1, 4);
    cw_write(8'h08, 1);
    idle(1, 2);
    cw_write(8'h09, 1);
    read_a(1);
    idle(0, 4);
    idle(1, 4);
    step(1, 0, 0, 0, 2'd0, 8'h00, 1);
    idle(1, 3);

    // random traffic
    cur_stb = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) cur_stb = ~cur_stb;
      pick = $urandom_range(0, 99);
      if (pick < 1) begin
        step(1, 0, 0, 0, 2'd0, 8'h00, cur_stb);
      end else if (pick < 4) begin
        case ($urandom_range(0, 4))
          0: d = 8'hB0;
          1: d = 8'hA9 | 8'(($urandom_range(0, 1)) << 4);
          2: d = 8'h80 | 8'($urandom_range(0, 31));
          3: d = 8'hC0 | 8'($urandom_range(0, 63));
          default: d = 8'($urandom_range(0, 255));
        endcase
        cw_write(d, cur_stb);
      end else if (pick < 12) begin
        d = 8'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) d = {4'h0, 3'd4, d[0]};
        cw_write(d, cur_stb);
      end else if (pick < 30) begin
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), cur_stb);
      end else begin
        step(0, 0, 0, 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), cur_stb);
      end
    end

    idle(1, 2);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
